// File: rtl/iddmm_pkg.sv
// Shared types and defaults for the IDDMM multiplier sharing logic.
// The tag id field is sized for the largest supported requester count (8).
package iddmm_pkg;

    localparam int DATA_W_DEF  = 128;
    localparam int MUL_LAT_DEF = 7;
    localparam int ID_W_MAX    = 3;

    typedef struct packed {
        logic                vld;
        logic [ID_W_MAX-1:0] id;
        logic                lo;
    } mul_tag_t;

endpackage

// File: rtl/iddmm_mul_arbiter_rr_arbiter.sv
// Round-robin arbiter: the first request at or after the pointer wins.
// The pointer moves just past the winner whenever an issue happens.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = ptr_q;
        for (int k = 0; k < N; k++) begin
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == PW'(N - 1)) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/iddmm_mul_arbiter.sv
// Shares one fixed-latency, non-stallable multiplier between NUM_REQ requesters.
// A tag pipeline matched to MUL_LAT marks which multiplier outputs belong to real issues.
module iddmm_mul_arbiter
    import iddmm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int ID_W    = $clog2(NUM_REQ),
    localparam int CNT_W  = $clog2(MUL_LAT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    input  logic [NUM_REQ*DATA_W-1:0] req_y,
    input  logic [NUM_REQ-1:0]        req_lo,
    output logic [DATA_W-1:0]         mul_x,
    output logic [DATA_W-1:0]         mul_y,
    input  logic [2*DATA_W-1:0]       mul_result,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [2*DATA_W-1:0]       resp_data,
    output logic [CNT_W-1:0]          inflight,
    output logic                      busy
);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    rr_ptr;
    logic               issue;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (en),
        .advance   (issue),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .ptr       (rr_ptr)
    );

    assign req_ready = gnt;
    assign issue     = |gnt;

    logic [DATA_W-1:0]   mul_x_q, mul_x_d, mul_y_q, mul_y_d;
    mul_tag_t            tag_q [MUL_LAT];
    mul_tag_t            tag_d [MUL_LAT];
    mul_tag_t            out_tag;
    logic                resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic [2*DATA_W-1:0] resp_data_q, resp_data_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic                busy_q, busy_d;

    always_comb begin
        tag_d[0]     = '0;
        tag_d[0].vld = issue;
        tag_d[0].id  = ID_W_MAX'(gnt_idx);
        tag_d[0].lo  = req_lo[gnt_idx];
    end

    for (genvar gi = 1; gi < MUL_LAT; gi++) begin : g_tag_shift
        always_comb tag_d[gi] = tag_q[gi-1];
    end

    assign out_tag = tag_q[MUL_LAT-1];

    always_comb begin
        mul_x_d = mul_x_q;
        mul_y_d = mul_y_q;
        if (issue) begin
            mul_x_d = req_x[int'(gnt_idx)*DATA_W +: DATA_W];
            mul_y_d = req_y[int'(gnt_idx)*DATA_W +: DATA_W];
        end

        // Multiplier outputs without a valid tag are stale or pre-reset and are dropped.
        resp_valid_d = out_tag.vld;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        if (out_tag.vld) begin
            resp_id_d   = out_tag.id[ID_W-1:0];
            resp_data_d = out_tag.lo ? {{DATA_W{1'b0}}, mul_result[DATA_W-1:0]} : mul_result;
        end

        case ({issue, out_tag.vld})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        busy_d = (inflight_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_x_q      <= '0;
            mul_y_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            inflight_q   <= '0;
            busy_q       <= 1'b0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            mul_x_q      <= mul_x_d;
            mul_y_q      <= mul_y_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            inflight_q   <= inflight_d;
            busy_q       <= busy_d;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rr_ptr, out_tag.id};

    assign mul_x      = mul_x_q;
    assign mul_y      = mul_y_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign inflight   = inflight_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_iddmm_mul_arbiter.sv
// Directed and random bench for iddmm_mul_arbiter with a 7-cycle multiplier model
// and an issue-order scoreboard sampled on the falling edge.
module tb_iddmm_mul_arbiter;

    localparam int N   = 4;
    localparam int DW  = 128;
    localparam int LAT = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_lo = '0;
    logic [N*DW-1:0]   req_x = '0;
    logic [N*DW-1:0]   req_y = '0;
    logic [DW-1:0]     mul_x, mul_y;
    logic [2*DW-1:0]   mul_result;
    logic              resp_valid;
    logic [1:0]        resp_id;
    logic [2*DW-1:0]   resp_data;
    logic [2:0]        inflight;
    logic              busy;

    always #5 clk = ~clk;

    iddmm_mul_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MUL_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_lo     (req_lo),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_result (mul_result),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .inflight   (inflight),
        .busy       (busy)
    );

    // Multiplier: product of operands loaded at edge E is on mul_result after edge E+LAT-1.
    logic [2*DW-1:0] mp [LAT-1];
    always @(posedge clk) begin
        mp[0] <= {{DW{1'b0}}, mul_x} * {{DW{1'b0}}, mul_y};
        for (int i = 1; i < LAT - 1; i++) mp[i] <= mp[i-1];
    end
    assign mul_result = mp[LAT-2];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] rr_model(input logic [N-1:0] v, input logic e, input int p);
        logic [N-1:0] r;
        r = '0;
        if (e) begin
            for (int k = 0; k < N; k++) begin
                if (v[(p + k) % N]) begin
                    r[(p + k) % N] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    typedef struct {
        int              due;
        logic [1:0]      id;
        logic [2*DW-1:0] data;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            e_pop, e_new;
    logic [N-1:0]    g_exp;
    int              mptr = 0;
    int              g_id;
    logic [2*DW-1:0] xa, ya;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: checks responses, occupancy and grant, then records the upcoming issue.
    always @(negedge clk) begin
        if (mon_on) begin
            if (resp_valid) begin
                $display("resp id=%0d data=%0h cyc=%0d", resp_id, resp_data, cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 1'b1, 1'b0);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk("resp_cycle", cyc, e_pop.due);
                    chk("resp_id", resp_id, e_pop.id);
                    chk("resp_data", resp_data, e_pop.data);
                end
            end
            if (exp_q.size() != 0) chk("resp_not_overdue", exp_q[0].due > cyc, 1'b1);
            chk("inflight", inflight, exp_q.size());
            chk("busy", busy, exp_q.size() != 0);
            g_exp = rr_model(req_valid, en, mptr);
            chk("grant", req_ready, g_exp);
            if (!rst_n) begin
                exp_q.delete();
                mptr = 0;
            end else if (g_exp != '0) begin
                g_id = 0;
                for (int i = 0; i < N; i++) if (g_exp[i]) g_id = i;
                xa = {{DW{1'b0}}, req_x[g_id*DW +: DW]};
                ya = {{DW{1'b0}}, req_y[g_id*DW +: DW]};
                e_new.due  = cyc + LAT + 1;
                e_new.id   = 2'(g_id);
                e_new.data = xa * ya;
                if (req_lo[g_id]) e_new.data[2*DW-1:DW] = '0;
                exp_q.push_back(e_new);
                mptr = (g_id + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        req_valid = '0;
        step();
        chk("rst_mul_x", mul_x, 0);
        chk("rst_mul_y", mul_y, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_x[i*DW +: DW] = {$urandom(), $urandom(), $urandom(), $urandom()};
            req_y[i*DW +: DW] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    logic [N-1:0] g_want;

    initial begin
        step();
        do_reset();
        mon_on = 1'b1;

        // Single issue from requester 2: 3*5 after exactly LAT cycles.
        en = 1'b1;
        req_x[2*DW +: DW] = 128'h3;
        req_y[2*DW +: DW] = 128'h5;
        req_lo = '0;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        chk("single_inflight_E", inflight, 1);
        chk("single_novalid_E", resp_valid, 0);
        for (int k = 1; k < LAT; k++) begin
            step();
            chk("single_novalid", resp_valid, 0);
            chk("single_inflight", inflight, 1);
        end
        step();
        chk("single_valid", resp_valid, 1);
        chk("single_id", resp_id, 2);
        chk("single_data", resp_data, 256'hF);
        chk("single_inflight_done", inflight, 0);
        step();
        chk("single_pulse", resp_valid, 0);

        // Round-robin fairness with all requesters asserted.
        do_reset();
        en = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            #1;
            g_want = 4'(1 << (k % N));
            chk("rr_order", req_ready, g_want);
            step();
        end
        drain(LAT + 3);

        // Low-half mode: all-ones squared keeps only the low word, which is 1.
        req_x[1*DW +: DW] = {DW{1'b1}};
        req_y[1*DW +: DW] = {DW{1'b1}};
        req_lo = 4'b0010;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        req_lo = '0;
        for (int k = 0; k < 12 && !resp_valid; k++) step();
        chk("lo_seen", resp_valid, 1);
        chk("lo_upper_zero", resp_data[2*DW-1:DW], 0);
        chk("lo_lower_one", resp_data[DW-1:0], 1);
        drain(2);

        // Enable gating: grants 2,3 then freeze; pointer must come back at 0.
        req_valid = 4'hF;
        rand_ops();
        step();
        rand_ops();
        step();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("en_off_ready", req_ready, 0);
            step();
        end
        en = 1'b1;
        #1;
        chk("en_resume_ptr", req_ready, 4'b0001);
        step();
        drain(LAT + 3);

        // Reset mid-flight: three issues (1,2,0) are discarded and the pointer returns to 0.
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        step();
        step();
        do_reset();
        en = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("rst_ptr_zero", req_ready, 4'b0001);
        req_valid = '0;
        for (int k = 0; k < LAT + 3; k++) begin
            step();
            chk("rst_no_resp", resp_valid, 0);
        end

        // Random soak.
        for (int k = 0; k < 1000; k++) begin
            rand_ops();
            req_valid = 4'($urandom());
            req_lo = 4'($urandom());
            en = ($urandom_range(0, 3) != 0);
            #1;
            chk("soak_grant_valid", req_ready & ~req_valid, 0);
            step();
        end
        en = 1'b1;
        drain(LAT + 3);
        chk("soak_all_returned", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iddmm_mul_arbiter.md
Name: iddmm_mul_arbiter

Overview:
- Shares one fully pipelined, non-stallable 128x128 multiplier (iddmm_mul_128_to_256) between NUM_REQ requesters, such as the Montgomery and exponentiation engines of the Paillier core.
- Grants requests round-robin, at most one issue per cycle.
- Tracks each in-flight operation with a tag pipeline matched to the multiplier latency.
- Returns each product with the originating requester id.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 128, operand width; product is 2*DATA_W.
- MUL_LAT, 7, cycles from the clock edge that loads mul_x/mul_y to the edge at which mul_result holds their product.
- ID_W, $clog2(NUM_REQ), requester id width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  grant enable; when 0 no new issue, in-flight operations still complete.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero).
- req_x  in  NUM_REQ*DATA_W  packed operand x; requester i occupies [i*DATA_W +: DATA_W].
- req_y  in  NUM_REQ*DATA_W  packed operand y, same packing.
- req_lo  in  NUM_REQ  per-requester flag: return only the low DATA_W bits (upper half zeroed).
- mul_x  out  DATA_W  registered operand to multiplier.
- mul_y  out  DATA_W  registered operand to multiplier.
- mul_result  in  2*DATA_W  multiplier product.
- resp_valid  out  1  product valid, single-cycle pulse.
- resp_id  out  ID_W  requester index of this product.
- resp_data  out  2*DATA_W  product; upper DATA_W zero when the op was issued with req_lo=1.
- inflight  out  $clog2(MUL_LAT+1)  number of issued, not yet returned ops.
- busy  out  1  inflight != 0.

Behaviour:
- Reset (rst_n=0 at a posedge) clears all state:
  - mul_x, mul_y, resp_data: 0.
  - resp_valid, busy: 0; resp_id: 0; inflight: 0.
  - Tag pipeline valid bits: 0.
  - Round-robin pointer: 0, so requester 0 has highest priority first.
- Grant is combinational: req_ready[i]=1 only when en=1, req_valid[i]=1, and i is the first asserted requester at or after the pointer, wrapping modulo NUM_REQ. At most one bit is set.
- A handshake (req_valid[i] & req_ready[i] at posedge E) is an issue:
  - mul_x/mul_y load req_x/req_y slice i.
  - Tag {valid=1, id=i, lo=req_lo[i]} enters stage 0 of the tag pipeline.
  - Pointer becomes (i+1) mod NUM_REQ.
- No issue at a posedge: mul_x/mul_y hold their values, a valid=0 tag enters stage 0, and the pointer holds.
- The tag pipeline has MUL_LAT stages and shifts every cycle, with no stall.
- The stage MUL_LAT-1 tag is registered together with mul_result into resp_valid/resp_id/resp_data. An op issued at edge E therefore produces a resp_valid pulse after edge E+MUL_LAT, with resp_data = mul_result captured at that edge. Product is ready after E+MUL_LAT-1, registered at E+MUL_LAT.
  - Total issue-to-response latency is exactly MUL_LAT cycles.
- lo=1: resp_data = {DATA_W'0, mul_result[DATA_W-1:0]}.
- resp_valid=0: resp_data and resp_id hold their last values.
- Responses carry no backpressure; requesters must accept resp_valid whenever it is asserted.
- Throughput: one issue per cycle sustained; back-to-back issues produce back-to-back responses in issue order.
- inflight increments on issue and decrements on response. Simultaneous issue and response leaves it unchanged. It never exceeds MUL_LAT.
- en deasserted mid-stream: the pipeline drains normally and the pointer is frozen.
- Reset mid-operation: all tags are cleared, so no resp_valid follows for ops issued before reset, even though the multiplier still emits products. Products not matched by a valid tag are ignored.
- Single requester asserting continuously: it is granted every cycle; wrap-around returns to it.
- A requester may drop req_valid without a handshake; no state changes.

Decomposition:
- Shared package iddmm_pkg:
  - DATA_W and MUL_LAT defaults.
  - Typedef mul_tag_t {logic vld; logic [ID_W-1:0] id; logic lo;}.
- One sub-module, rr_arbiter (parameter N): request vector, enable and advance in; one-hot grant and pointer state out.
- Tag pipeline and output register live in the top module.

Test Plan:
- Single issue: after reset, requester 2 issues x=0x3, y=0x5, lo=0 at edge E. Required: resp_valid only after E+7, resp_id=2, resp_data=0xF, inflight=1 during E+1..E+7, then 0.
- Round-robin fairness: all 4 requesters hold valid for 8 cycles with en=1. Required:
  - Grant order 0,1,2,3,0,1,2,3.
  - Responses 7 cycles later in the same order, each matching the golden x*y.
- Low-half mode: requester 1 issues x=y=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF with lo=1. Required: resp_data[255:128]=0 and resp_data[127:0]=0x...0001.
- Enable gating: en=0 for 5 cycles with all valid asserted. Required:
  - req_ready=0 throughout.
  - In-flight ops still return.
  - On en=1 the grant resumes at the frozen pointer.
- Reset mid-flight: issue 3 ops, assert rst_n=0 for 1 cycle 2 cycles later. Required: no resp_valid for those ops, inflight=0, pointer=0.
- Random soak: 1000 cycles of random valid/en/operands. Required:
  - Every issued op is returned exactly once after 7 cycles with the correct id and product.
  - inflight never exceeds 7.
  - No grant goes to a requester with req_valid=0.
